// File: rtl/commit_store_buffer.sv
// Two-level store buffer: speculative FIFO -> commit FIFO -> D$ write port via a req/gnt drain FSM.
// Optional macro CVA6_SB_PAGE_MATCH_EN enables exact page-offset aliasing; otherwise the hazard check is conservative.
module commit_store_buffer #(
   parameter int unsigned SPEC_DEPTH   = 4,
   parameter int unsigned COMMIT_DEPTH = 4,
   parameter int unsigned PLEN         = 56,
   parameter int unsigned XLEN         = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic [PLEN-1:0]   paddr_i,
   input  logic [XLEN-1:0]   data_i,
   input  logic [XLEN/8-1:0] be_i,
   input  logic [1:0]        size_i,
   output logic              ready_o,
   input  logic              commit_i,
   output logic              commit_ready_o,
   output logic              no_st_pending_o,
   input  logic [11:0]       page_offset_i,
   output logic              page_offset_match_o,
   output logic              req_o,
   output logic [PLEN-1:0]   addr_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic [XLEN/8-1:0] be_o,
   output logic [1:0]        size_o,
   input  logic              gnt_i
);

   localparam int unsigned SPTR_W = $clog2(SPEC_DEPTH);
   localparam int unsigned SCNT_W = SPTR_W + 1;
   localparam int unsigned CPTR_W = $clog2(COMMIT_DEPTH);
   localparam int unsigned CCNT_W = CPTR_W + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] REQ  = 1'b1;

   typedef struct packed {
      logic [PLEN-1:0]   paddr;
      logic [XLEN-1:0]   data;
      logic [XLEN/8-1:0] be;
      logic [1:0]        size;
   } sb_entry_t;

   sb_entry_t spec_mem_q   [SPEC_DEPTH];
   sb_entry_t commit_mem_q [COMMIT_DEPTH];

   logic [SPTR_W-1:0] spec_wr_q, spec_wr_d, spec_rd_q, spec_rd_d;
   logic [SCNT_W-1:0] spec_cnt_q, spec_cnt_d;
   logic [CPTR_W-1:0] commit_wr_q, commit_wr_d, commit_rd_q, commit_rd_d;
   logic [CCNT_W-1:0] commit_cnt_q, commit_cnt_d;
   logic [0:0]        state_q, state_d;

   logic      push_en, commit_en, pop_en;
   sb_entry_t push_entry, head_entry;

   assign ready_o        = (spec_cnt_q != SCNT_W'(SPEC_DEPTH));
   assign commit_ready_o = (commit_cnt_q != CCNT_W'(COMMIT_DEPTH));

   // Handshakes use registered counts only: a same-cycle pop never frees a slot early.
   assign push_en   = valid_i & ready_o & ~flush_i;
   assign commit_en = commit_i & commit_ready_o & (spec_cnt_q != '0);
   assign pop_en    = (state_q == REQ) & gnt_i;

   assign push_entry = '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};
   assign head_entry = commit_mem_q[commit_rd_q];

   always_comb begin
      spec_wr_d  = spec_wr_q;
      spec_rd_d  = spec_rd_q;
      spec_cnt_d = spec_cnt_q;
      if (flush_i) begin
         spec_wr_d  = '0;
         spec_rd_d  = '0;
         spec_cnt_d = '0;
      end else begin
         if (push_en)   spec_wr_d = spec_wr_q + SPTR_W'(1);
         if (commit_en) spec_rd_d = spec_rd_q + SPTR_W'(1);
         case ({push_en, commit_en})
            2'b10:   spec_cnt_d = spec_cnt_q + SCNT_W'(1);
            2'b01:   spec_cnt_d = spec_cnt_q - SCNT_W'(1);
            default: spec_cnt_d = spec_cnt_q;
         endcase
      end
   end

   always_comb begin
      commit_wr_d  = commit_wr_q;
      commit_rd_d  = commit_rd_q;
      commit_cnt_d = commit_cnt_q;
      if (commit_en) commit_wr_d = commit_wr_q + CPTR_W'(1);
      if (pop_en)    commit_rd_d = commit_rd_q + CPTR_W'(1);
      case ({commit_en, pop_en})
         2'b10:   commit_cnt_d = commit_cnt_q + CCNT_W'(1);
         2'b01:   commit_cnt_d = commit_cnt_q - CCNT_W'(1);
         default: commit_cnt_d = commit_cnt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (commit_cnt_q != '0) state_d = REQ;
         REQ:  if (gnt_i && (commit_cnt_q == CCNT_W'(1)) && !commit_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         spec_wr_q    <= '0;
         spec_rd_q    <= '0;
         spec_cnt_q   <= '0;
         commit_wr_q  <= '0;
         commit_rd_q  <= '0;
         commit_cnt_q <= '0;
         state_q      <= IDLE;
      end else begin
         spec_wr_q    <= spec_wr_d;
         spec_rd_q    <= spec_rd_d;
         spec_cnt_q   <= spec_cnt_d;
         commit_wr_q  <= commit_wr_d;
         commit_rd_q  <= commit_rd_d;
         commit_cnt_q <= commit_cnt_d;
         state_q      <= state_d;
      end
   end

   // Payload storage carries no reset; validity is tracked entirely by the counts.
   always_ff @(posedge clk_i) begin
      if (push_en)   spec_mem_q[spec_wr_q]     <= push_entry;
      if (commit_en) commit_mem_q[commit_wr_q] <= spec_mem_q[spec_rd_q];
   end

   assign req_o           = (state_q == REQ);
   assign addr_o          = head_entry.paddr;
   assign wdata_o         = head_entry.data;
   assign be_o            = head_entry.be;
   assign size_o          = head_entry.size;
   assign no_st_pending_o = (commit_cnt_q == '0) && (state_q == IDLE);

   logic unused_pgoff;
   assign unused_pgoff = ^page_offset_i;

`ifdef CVA6_SB_PAGE_MATCH_EN
   function automatic logic spec_slot_valid(input logic [SPTR_W-1:0] idx);
      logic [SPTR_W-1:0] off;
      off = idx - spec_rd_q;
      return ({1'b0, off} < spec_cnt_q);
   endfunction

   function automatic logic commit_slot_valid(input logic [CPTR_W-1:0] idx);
      logic [CPTR_W-1:0] off;
      off = idx - commit_rd_q;
      return ({1'b0, off} < commit_cnt_q);
   endfunction

   always_comb begin
      page_offset_match_o = 1'b0;
      for (int i = 0; i < SPEC_DEPTH; i++) begin
         if (spec_slot_valid(SPTR_W'(i)) &&
             (spec_mem_q[i].paddr[11:3] == page_offset_i[11:3]))
            page_offset_match_o = 1'b1;
      end
      for (int j = 0; j < COMMIT_DEPTH; j++) begin
         if (commit_slot_valid(CPTR_W'(j)) &&
             (commit_mem_q[j].paddr[11:3] == page_offset_i[11:3]))
            page_offset_match_o = 1'b1;
      end
   end
`else
   assign page_offset_match_o = (spec_cnt_q != '0) || (commit_cnt_q != '0);
`endif

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer: reset, latency, fill, flush, simultaneous push/commit, hazard.
module tb_commit_store_buffer;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        flush_i, valid_i, commit_i, gnt_i;
   logic [55:0] paddr_i;
   logic [63:0] data_i;
   logic [7:0]  be_i;
   logic [1:0]  size_i;
   logic [11:0] page_offset_i;
   logic        ready_o, commit_ready_o, no_st_pending_o, page_offset_match_o, req_o;
   logic [55:0] addr_o;
   logic [63:0] wdata_o;
   logic [7:0]  be_o;
   logic [1:0]  size_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [55:0] exp_addr [8];
   logic        exp_hit_far;

   always #5 clk_i = ~clk_i;

   commit_store_buffer dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
      .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i),
      .ready_o(ready_o), .commit_i(commit_i), .commit_ready_o(commit_ready_o),
      .no_st_pending_o(no_st_pending_o), .page_offset_i(page_offset_i),
      .page_offset_match_o(page_offset_match_o), .req_o(req_o), .addr_o(addr_o),
      .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o), .gnt_i(gnt_i)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [55:0] a, input logic [63:0] d);
      valid_i = 1'b1; paddr_i = a; data_i = d; be_i = 8'h01; size_i = 2'd0;
      tick();
      valid_i = 1'b0;
   endtask

   task automatic commit_one();
      commit_i = 1'b1;
      tick();
      commit_i = 1'b0;
   endtask

   // Grant every request and compare issued addresses against exp_addr in order.
   task automatic drain(input string tag, input int n);
      int got;
      got = 0;
      gnt_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (req_o) begin
            if (got < n) check(tag, addr_o, exp_addr[got]);
            got++;
         end
         tick();
      end
      gnt_i = 1'b0;
      check({tag, "_writes"}, got, n);
      check({tag, "_nsp"}, no_st_pending_o, 1);
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 0; valid_i = 0; commit_i = 0; gnt_i = 0;
      paddr_i = '0; data_i = '0; be_i = '0; size_i = '0; page_offset_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", ready_o, 1);
      check("rst_cready", commit_ready_o, 1);
      check("rst_nsp", no_st_pending_o, 1);
      check("rst_req", req_o, 0);
      check("rst_match", page_offset_match_o, 0);
      rst_i = 1'b0;
      tick();

      // Single store: req_o two edges after commit, idle one edge after gnt.
      push(56'h1000, 64'hAA);
      commit_i = 1'b1;
      check("t2_req_c0", req_o, 0);
      tick();
      commit_i = 1'b0;
      check("t2_req_c1", req_o, 0);
      tick();
      check("t2_req_c2", req_o, 1);
      check("t2_addr", addr_o, 56'h1000);
      check("t2_data", wdata_o, 64'hAA);
      check("t2_be", be_o, 8'h01);
      check("t2_nsp_busy", no_st_pending_o, 0);
      gnt_i = 1'b1;
      tick();
      gnt_i = 1'b0;
      check("t2_nsp_done", no_st_pending_o, 1);
      check("t2_req_done", req_o, 0);

      // Fill: 4 pushes fill, 5th dropped; 4 commits fill commit FIFO.
      for (int k = 0; k < 4; k++) begin
         exp_addr[k] = 56'h3000 + 56'(k) * 56'h100;
         push(exp_addr[k], 64'(k));
      end
      check("t3_ready_full", ready_o, 0);
      push(56'h3F00, 64'hFF);
      check("t3_spec_cnt", dut.spec_cnt_q, 4);
      for (int k = 0; k < 4; k++) commit_one();
      check("t3_cready_full", commit_ready_o, 0);
      check("t3_ready_free", ready_o, 1);
      drain("t3_order", 4);

      // Flush with same-cycle commit: committed head survives, rest killed.
      push(56'h4000, 64'h40);
      push(56'h4100, 64'h41);
      push(56'h4200, 64'h42);
      commit_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1; paddr_i = 56'h4300;
      tick();
      commit_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
      check("t4_spec_cnt", dut.spec_cnt_q, 0);
      check("t4_ready", ready_o, 1);
      exp_addr[0] = 56'h4000;
      drain("t4_flush", 1);

      // Simultaneous push+commit keeps spec count constant.
      push(56'h5000, 64'h50);
      push(56'h5100, 64'h51);
      valid_i = 1'b1; paddr_i = 56'h5200; data_i = 64'h52; commit_i = 1'b1;
      tick();
      valid_i = 1'b0; commit_i = 1'b0;
      check("t5_spec_cnt", dut.spec_cnt_q, 2);
      commit_one();
      commit_one();
      exp_addr[0] = 56'h5000; exp_addr[1] = 56'h5100; exp_addr[2] = 56'h5200;
      drain("t5_order", 3);

      // Hazard check against a buffered store.
`ifdef CVA6_SB_PAGE_MATCH_EN
      exp_hit_far = 1'b0;
`else
      exp_hit_far = 1'b1;
`endif
      push(56'h2_0008, 64'h77);
      page_offset_i = 12'h00C;
      #1;
      check("t6_match_near", page_offset_match_o, 1);
      page_offset_i = 12'h010;
      #1;
      check("t6_match_far", page_offset_match_o, exp_hit_far);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      page_offset_i = 12'h00C;
      #1;
      check("t6_match_empty", page_offset_match_o, 0);

      // Reset in the middle of a pending request.
      tick();
      push(56'h6000, 64'h60);
      commit_one();
      tick();
      check("t1_req_pre", req_o, 1);
      #2;
      rst_i = 1'b1;
      #1;
      check("t1_req_async", req_o, 0);
      check("t1_ready", ready_o, 1);
      check("t1_cready", commit_ready_o, 1);
      check("t1_nsp", no_st_pending_o, 1);
      tick();
      rst_i = 1'b0;
      tick();
      check("t1_req_after", req_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
